hazard_forward_ctrl: RTL and testbench

// - Producer side of the EX-stage operand forwarding interface. Generates the forward::

---
 rtl/hazard_forward_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl
//   Producer side of the EX-stage operand forwarding interface. Shadows the
//   destinations of the instructions in ID/EX, EX/MEM and MEM/WB. From those
//   shadows it drives the EX forward selects and the load-use stall/bubble.
//
//   Optional build macro: HAZARD_PERF_EN adds the stall/forward perf counters.
//   Without it, stall_cnt and fwd_cnt are tied to zero.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   id_valid                 ID holds a real instruction
//   id_rs1, id_rs2           ID source indices
//   id_use_rs1, id_use_rs2   ID instruction actually reads rs1 / rs2
//   id_rd, id_regwrite       ID destination index and write enable
//   id_is_load               ID instruction is a load
//   mem_ready                0 freezes the whole pipeline for this cycle
//   flush                    redirect resolved in EX; kills ID and EX
//   alumux1_fw, alumux2_fw   EX operand selects: 0 idex, 1 exmem, 2 memwb
//   stall_if_id              hold PC and IF/ID
//   bubble_ex                load a NOP into ID/EX
//   stall_cnt, fwd_cnt       perf counters (HAZARD_PERF_EN only)
module hazard_forward_ctrl #(
    parameter int REG_IDX_W   = 5,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [REG_IDX_W-1:0]   id_rs1,
    input  logic [REG_IDX_W-1:0]   id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_IDX_W-1:0]   id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic                   mem_ready,
    input  logic                   flush,
    output logic [1:0]             alumux1_fw,
    output logic [1:0]             alumux2_fw,
    output logic                   stall_if_id,
    output logic                   bubble_ex,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [STALL_CNT_W-1:0] fwd_cnt
);

    typedef struct packed {
        logic [REG_IDX_W-1:0] rs1;
        logic [REG_IDX_W-1:0] rs2;
        logic                 use_rs1;
        logic                 use_rs2;
    } src_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
        logic                 is_load;
    } dst_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 regwrite;
    } wb_t;

    logic vld_p0, vld_p1, vld_p2;
    src_t ex_src_p0;
    dst_t ex_dst_p0;
    dst_t mem_dst_p1;
    wb_t  wb_dst_p2;

    logic hz;
    logic kill;

    // The youngest producer (EX/MEM) wins over MEM/WB; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic                 use_rs,
        input logic [REG_IDX_W-1:0] rs,
        input logic                 mem_v,
        input dst_t                 mem_d,
        input logic                 wb_v,
        input wb_t                  wb_d
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (use_rs && rs != '0) begin
            if (mem_v && mem_d.regwrite && mem_d.rd == rs) begin
                sel = 2'd1;
            end else if (wb_v && wb_d.regwrite && wb_d.rd == rs) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        alumux1_fw = fwd_sel(ex_src_p0.use_rs1, ex_src_p0.rs1,
                             vld_p1, mem_dst_p1, vld_p2, wb_dst_p2);
        alumux2_fw = fwd_sel(ex_src_p0.use_rs2, ex_src_p0.rs2,
                             vld_p1, mem_dst_p1, vld_p2, wb_dst_p2);
    end

    // A load in EX whose result the ID instruction needs costs one bubble.
    // During a freeze the global hold already covers it, and a flush kills
    // both instructions, so neither raises a stall.
    always_comb begin
        hz = id_valid && vld_p0 && ex_dst_p0.is_load && ex_dst_p0.regwrite &&
             (ex_dst_p0.rd != '0) &&
             ((id_use_rs1 && id_rs1 == ex_dst_p0.rd) ||
              (id_use_rs2 && id_rs2 == ex_dst_p0.rd));
        stall_if_id = hz && mem_ready && !flush;
        bubble_ex   = stall_if_id;
        kill        = bubble_ex || flush;
    end

    // Valid bits are the only reset state; a dropped record carries no forwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (mem_ready) begin
            vld_p0 <= kill ? 1'b0 : id_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // ID -> EX (p0) -> MEM (p1) -> WB (p2); killed entries also clear their
    // fields so a bubble never requests a forward.
    always_ff @(posedge clk) begin
        if (mem_ready) begin
            if (kill) begin
                ex_src_p0 <= '0;
                ex_dst_p0 <= '0;
            end else begin
                ex_src_p0 <= '{rs1: id_rs1, rs2: id_rs2,
                               use_rs1: id_use_rs1, use_rs2: id_use_rs2};
                ex_dst_p0 <= '{rd: id_rd, regwrite: id_regwrite, is_load: id_is_load};
            end
            mem_dst_p1 <= ex_dst_p0;
            wb_dst_p2  <= '{rd: mem_dst_p1.rd, regwrite: mem_dst_p1.regwrite};
        end
    end

`ifndef SYNTHESIS
    // The one-cycle load-use bubble guarantees EX never depends on a load in MEM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(vld_p0 && vld_p1 && mem_dst_p1.is_load && mem_dst_p1.regwrite &&
                      (mem_dst_p1.rd != '0) &&
                      ((ex_src_p0.use_rs1 && ex_src_p0.rs1 == mem_dst_p1.rd) ||
                       (ex_src_p0.use_rs2 && ex_src_p0.rs2 == mem_dst_p1.rd))))
            else $error("load in MEM feeds the instruction in EX");
        end
    end
`endif

`ifdef HAZARD_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] fwd_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (stall_if_id) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (mem_ready && (alumux1_fw != 2'd0 || alumux2_fw != 2'd0)) begin
                fwd_cnt_q <= fwd_cnt_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: a cycle-by-cycle vector table
// covering forwarding, priority, x0, load-use, freeze and flush, followed by
// an asynchronous reset mid-stream and perf counter checks.
module tb_hazard_forward_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_regwrite, id_is_load;
    logic        mem_ready, flush;
    logic [1:0]  alumux1_fw, alumux2_fw;
    logic        stall_if_id, bubble_ex;
    logic [31:0] stall_cnt, fwd_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_IDX_W(5), .STALL_CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .id_rd       (id_rd),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .alumux1_fw  (alumux1_fw),
        .alumux2_fw  (alumux2_fw),
        .stall_if_id (stall_if_id),
        .bubble_ex   (bubble_ex),
        .stall_cnt   (stall_cnt),
        .fwd_cnt     (fwd_cnt)
    );

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       ld;
    } id_t;

    typedef struct {
        id_t        id;
        logic       mr;
        logic       fl;
        logic [1:0] e1;
        logic [1:0] e2;
        logic       es;
    } vec_t;

    function automatic id_t ins(int v, int rs1, int rs2, int u1, int u2,
                                int rd, int rw, int ld);
        id_t r;
        r.v   = 1'(v);
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.u1  = 1'(u1);
        r.u2  = 1'(u2);
        r.rd  = 5'(rd);
        r.rw  = 1'(rw);
        r.ld  = 1'(ld);
        return r;
    endfunction

    function automatic vec_t mk(id_t id, int mr, int fl, int e1, int e2, int es);
        vec_t r;
        r.id = id;
        r.mr = 1'(mr);
        r.fl = 1'(fl);
        r.e1 = 2'(e1);
        r.e2 = 2'(e2);
        r.es = 1'(es);
        return r;
    endfunction

    task automatic drive(input id_t d, input logic mr, input logic fl);
        id_valid    = d.v;
        id_rs1      = d.rs1;
        id_rs2      = d.rs2;
        id_use_rs1  = d.u1;
        id_use_rs2  = d.u2;
        id_rd       = d.rd;
        id_regwrite = d.rw;
        id_is_load  = d.ld;
        mem_ready   = mr;
        flush       = fl;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vec_t tbl[40];
        id_t  nop, add5, add6, sub7, add5b, lw8, add9, addi0, add1x0, lw0, add2x0, add10, lw8r5;
        int   nstall, nfwd;

        //         v rs1 rs2 u1 u2 rd rw ld
        nop    = ins(0, 0, 0, 0, 0, 0, 0, 0);
        add5   = ins(1, 1, 2, 1, 1, 5, 1, 0);   // add  x5,x1,x2
        add6   = ins(1, 5, 3, 1, 1, 6, 1, 0);   // add  x6,x5,x3
        sub7   = ins(1, 3, 5, 1, 1, 7, 1, 0);   // sub  x7,x3,x5
        add5b  = ins(1, 2, 3, 1, 1, 5, 1, 0);   // add  x5,x2,x3
        lw8    = ins(1, 1, 0, 1, 0, 8, 1, 1);   // lw   x8,0(x1)
        add9   = ins(1, 8, 8, 1, 1, 9, 1, 0);   // add  x9,x8,x8
        addi0  = ins(1, 0, 0, 1, 0, 0, 1, 0);   // addi x0,x0,5
        add1x0 = ins(1, 0, 0, 1, 1, 1, 1, 0);   // add  x1,x0,x0
        lw0    = ins(1, 1, 0, 1, 0, 0, 1, 1);   // lw   x0,0(x1)
        add2x0 = ins(1, 0, 0, 1, 1, 2, 1, 0);   // add  x2,x0,x0
        add10  = ins(1, 8, 8, 1, 1, 10, 1, 0);  // add  x10,x8,x8
        lw8r5  = ins(1, 5, 0, 1, 0, 8, 1, 1);   // lw   x8,0(x5)

        //             id      mr fl e1 e2 stall
        tbl[0]  = mk(add5,   1, 0, 0, 0, 0);
        tbl[1]  = mk(add6,   1, 0, 0, 0, 0);
        tbl[2]  = mk(nop,    1, 0, 1, 0, 0);    // add6 in EX, add5 in MEM
        tbl[3]  = mk(add5,   1, 0, 0, 0, 0);
        tbl[4]  = mk(nop,    1, 0, 0, 0, 0);
        tbl[5]  = mk(sub7,   1, 0, 0, 0, 0);
        tbl[6]  = mk(nop,    1, 0, 0, 2, 0);    // sub in EX, add5 in WB
        tbl[7]  = mk(add5,   1, 0, 0, 0, 0);
        tbl[8]  = mk(add5b,  1, 0, 0, 0, 0);
        tbl[9]  = mk(sub7,   1, 0, 0, 0, 0);
        tbl[10] = mk(nop,    1, 0, 0, 1, 0);    // x5 in MEM and WB: MEM wins
        tbl[11] = mk(nop,    1, 0, 0, 0, 0);
        tbl[12] = mk(lw8,    1, 0, 0, 0, 0);
        tbl[13] = mk(add9,   1, 0, 0, 0, 1);    // load-use stall
        tbl[14] = mk(add9,   1, 0, 0, 0, 0);    // held in ID, bubble in EX
        tbl[15] = mk(nop,    1, 0, 2, 2, 0);    // add9 in EX, load in WB
        tbl[16] = mk(addi0,  1, 0, 0, 0, 0);
        tbl[17] = mk(add1x0, 1, 0, 0, 0, 0);
        tbl[18] = mk(nop,    1, 0, 0, 0, 0);    // x0 not forwarded
        tbl[19] = mk(lw0,    1, 0, 0, 0, 0);
        tbl[20] = mk(add2x0, 1, 0, 2, 0, 0);    // no stall on x0; lw rs1 from WB add x1
        tbl[21] = mk(nop,    1, 0, 0, 0, 0);
        tbl[22] = mk(lw8,    1, 0, 0, 0, 0);
        tbl[23] = mk(add9,   0, 0, 0, 0, 0);    // frozen: no stall
        tbl[24] = mk(add9,   0, 0, 0, 0, 0);
        tbl[25] = mk(add9,   0, 0, 0, 0, 0);
        tbl[26] = mk(add9,   1, 0, 0, 0, 1);    // first unfrozen cycle stalls
        tbl[27] = mk(add9,   1, 0, 0, 0, 0);
        tbl[28] = mk(nop,    0, 0, 2, 2, 0);    // frozen, selects held
        tbl[29] = mk(nop,    1, 0, 2, 2, 0);
        tbl[30] = mk(lw8,    1, 0, 0, 0, 0);
        tbl[31] = mk(add9,   1, 1, 0, 0, 0);    // flush beats stall
        tbl[32] = mk(add10,  1, 0, 0, 0, 0);    // EX was killed: no stall
        tbl[33] = mk(nop,    1, 0, 2, 2, 0);
        tbl[34] = mk(lw8,    1, 0, 0, 0, 0);
        tbl[35] = mk(add9,   0, 1, 0, 0, 0);    // flush during freeze ignored
        tbl[36] = mk(add9,   1, 0, 0, 0, 1);    // load survived: stall
        tbl[37] = mk(add9,   1, 0, 0, 0, 0);
        tbl[38] = mk(nop,    1, 0, 2, 2, 0);
        tbl[39] = mk(nop,    1, 0, 0, 0, 0);

        rst = 1'b1;
        drive(nop, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_fw1",    int'(alumux1_fw),  0);
        chk("rst_fw2",    int'(alumux2_fw),  0);
        chk("rst_stall",  int'(stall_if_id), 0);
        chk("rst_bubble", int'(bubble_ex),   0);
        chk("rst_scnt",   int'(stall_cnt),   0);
        chk("rst_fcnt",   int'(fwd_cnt),     0);
        rst = 1'b0;

        nstall = 0;
        nfwd   = 0;
        for (int i = 0; i < 40; i++) begin
            drive(tbl[i].id, tbl[i].mr, tbl[i].fl);
            #4;
            chk($sformatf("v%0d_fw1", i),    int'(alumux1_fw),  int'(tbl[i].e1));
            chk($sformatf("v%0d_fw2", i),    int'(alumux2_fw),  int'(tbl[i].e2));
            chk($sformatf("v%0d_stall", i),  int'(stall_if_id), int'(tbl[i].es));
            chk($sformatf("v%0d_bubble", i), int'(bubble_ex),   int'(tbl[i].es));
            if (tbl[i].es) nstall++;
            if (tbl[i].mr && (tbl[i].e1 != 2'd0 || tbl[i].e2 != 2'd0)) nfwd++;
            @(posedge clk);
            #1;
        end

        drive(add5, 1'b1, 1'b0);
        #4;
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", int'(stall_cnt), nstall);
        chk("fwd_cnt",   int'(fwd_cnt),   nfwd);
`else
        chk("stall_cnt_off", int'(stall_cnt), 0);
        chk("fwd_cnt_off",   int'(fwd_cnt),   0);
`endif
        @(posedge clk);
        #1;
        drive(lw8r5, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        drive(add9, 1'b1, 1'b0);
        #4;
        chk("pre_rst_fw1",   int'(alumux1_fw),  1);
        chk("pre_rst_stall", int'(stall_if_id), 1);

        rst = 1'b1;
        #1;
        chk("async_rst_fw1",   int'(alumux1_fw),  0);
        chk("async_rst_fw2",   int'(alumux2_fw),  0);
        chk("async_rst_stall", int'(stall_if_id), 0);
        chk("async_rst_scnt",  int'(stall_cnt),   0);
        chk("async_rst_fcnt",  int'(fwd_cnt),     0);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_stall", int'(stall_if_id), 0);
        @(posedge clk);
        #1;
        drive(nop, 1'b1, 1'b0);
        #4;
        chk("post_rst_fw1_a", int'(alumux1_fw), 0);
        chk("post_rst_fw2_a", int'(alumux2_fw), 0);
        @(posedge clk);
        #1;
        chk("post_rst_fw1_b", int'(alumux1_fw), 0);
        chk("post_rst_fw2_b", int'(alumux2_fw), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
